channel_sweep_ctrl: RTL

CHANNEL_SWEEP_CTRL -- requirements
Module: channel_sweep_ctrl

---
 rtl/channel_ctrl_pkg.sv | 18 +
 rtl/channel_sweep_ctrl_if.sv | 35 +++
 rtl/channel_scale_table.sv | 29 ++
 rtl/channel_sweep_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/channel_ctrl_pkg.sv
// rtl/channel_ctrl_pkg.sv - shared types and defaults for the channel sweep controller
package channel_ctrl_pkg;

  localparam int SAMPLE_W = 18;

  localparam int DEF_NUM_STEPS     = 8;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam logic signed [SAMPLE_W-1:0] DEF_SCALE_RESET = 18'sd16640;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_RUN,
    S_NEXT,
    S_FIN
  } state_t;

endpackage

// File: rtl/channel_sweep_ctrl_if.sv
// rtl/channel_sweep_ctrl_if.sv - sweep control, sample strobe and scale-table config bundle
interface channel_sweep_ctrl_if
  import channel_ctrl_pkg::*;
#(
  parameter int NUM_STEPS = DEF_NUM_STEPS
);
  localparam int IDX_W = $clog2(NUM_STEPS);

  logic                       start;
  logic                       abort;
  logic [15:0]                num_samples;
  logic [IDX_W-1:0]           last_step;
  logic                       sample_valid;
  logic                       cfg_we;
  logic [IDX_W-1:0]           cfg_addr;
  logic signed [SAMPLE_W-1:0] cfg_data;
  logic                       noise_en;
  logic signed [SAMPLE_W-1:0] noise_scale;
  logic [IDX_W-1:0]           step_idx;
  logic                       step_start;
  logic                       busy;
  logic                       done;
  logic                       cfg_err;

  modport master (
    output start, abort, num_samples, last_step, sample_valid, cfg_we, cfg_addr, cfg_data,
    input  noise_en, noise_scale, step_idx, step_start, busy, done, cfg_err
  );

  modport slave (
    input  start, abort, num_samples, last_step, sample_valid, cfg_we, cfg_addr, cfg_data,
    output noise_en, noise_scale, step_idx, step_start, busy, done, cfg_err
  );

endinterface

// File: rtl/channel_scale_table.sv
// rtl/channel_scale_table.sv - per-step noise scale register file, one write port, async read
module channel_scale_table
  import channel_ctrl_pkg::*;
#(
  parameter int NUM_STEPS = DEF_NUM_STEPS,
  parameter logic signed [SAMPLE_W-1:0] SCALE_RESET = DEF_SCALE_RESET
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              we,
  input  logic [$clog2(NUM_STEPS)-1:0]      waddr,
  input  logic signed [SAMPLE_W-1:0]        wdata,
  input  logic [$clog2(NUM_STEPS)-1:0]      raddr,
  output logic signed [SAMPLE_W-1:0]        rdata
);

  logic signed [SAMPLE_W-1:0] mem [NUM_STEPS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_STEPS; i++) mem[i] <= SCALE_RESET;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/channel_sweep_ctrl.sv
// rtl/channel_sweep_ctrl.sv - steps a noise scale through a table, settling then counting samples per step
module channel_sweep_ctrl
  import channel_ctrl_pkg::*;
#(
  parameter int NUM_STEPS = DEF_NUM_STEPS,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter logic signed [SAMPLE_W-1:0] SCALE_RESET = DEF_SCALE_RESET
) (
  input logic                 clk,
  input logic                 rst,
  channel_sweep_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_STEPS);
  localparam int SC_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0]  SC_LAST = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_STEPS - 1);

  state_t                     state;
  logic [15:0]                num_q;
  logic [15:0]                sample_cnt;
  logic [SC_W-1:0]            settle_cnt;
  logic [IDX_W-1:0]           last_q;
  logic [IDX_W-1:0]           step_q;
  logic [IDX_W-1:0]           last_in;
  logic [IDX_W-1:0]           rd_idx;
  logic signed [SAMPLE_W-1:0] rd_data;
  logic signed [SAMPLE_W-1:0] first_scale;
  logic                       tbl_we;
  logic                       noise_en_q, step_start_q, busy_q, done_q, cfg_err_q;
  logic signed [SAMPLE_W-1:0] scale_q;

  assign tbl_we  = bus.cfg_we && (state == S_IDLE);
  assign last_in = (int'(bus.last_step) >= NUM_STEPS) ? MAX_IDX : bus.last_step;
  // In IDLE the read port looks at step 0; during a sweep it looks one step ahead.
  assign rd_idx  = (state == S_IDLE) ? '0 : IDX_W'(step_q + 1'b1);
  // A write to entry 0 in the start cycle must reach the first step.
  assign first_scale = (tbl_we && (bus.cfg_addr == '0)) ? bus.cfg_data : rd_data;

  channel_scale_table #(
    .NUM_STEPS  (NUM_STEPS),
    .SCALE_RESET(SCALE_RESET)
  ) u_table (
    .clk  (clk),
    .rst  (rst),
    .we   (tbl_we),
    .waddr(bus.cfg_addr),
    .wdata(bus.cfg_data),
    .raddr(rd_idx),
    .rdata(rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      num_q        <= '0;
      sample_cnt   <= '0;
      settle_cnt   <= '0;
      last_q       <= '0;
      step_q       <= '0;
      noise_en_q   <= 1'b0;
      step_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      scale_q      <= SCALE_RESET;
    end else begin
      step_start_q <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= bus.cfg_we && (state != S_IDLE);
      if ((state != S_IDLE) && bus.abort) begin
        state      <= S_IDLE;
        noise_en_q <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              num_q      <= bus.num_samples;
              last_q     <= last_in;
              step_q     <= '0;
              settle_cnt <= '0;
              sample_cnt <= '0;
              busy_q     <= 1'b1;
              if (bus.num_samples == 16'd0) begin
                state <= S_FIN;
              end else begin
                state        <= S_SETTLE;
                step_start_q <= 1'b1;
                scale_q      <= first_scale;
              end
            end
          end
          S_SETTLE: begin
            if (settle_cnt == SC_LAST) begin
              state      <= S_RUN;
              noise_en_q <= 1'b1;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          S_RUN: begin
            if (bus.sample_valid) begin
              if (sample_cnt == num_q - 16'd1) begin
                state      <= S_NEXT;
                noise_en_q <= 1'b0;
              end else begin
                sample_cnt <= sample_cnt + 16'd1;
              end
            end
          end
          S_NEXT: begin
            if (step_q == last_q) begin
              state <= S_FIN;
            end else begin
              step_q       <= step_q + 1'b1;
              settle_cnt   <= '0;
              sample_cnt   <= '0;
              state        <= S_SETTLE;
              step_start_q <= 1'b1;
              scale_q      <= rd_data;
            end
          end
          S_FIN: begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.noise_en    = noise_en_q;
  assign bus.noise_scale = scale_q;
  assign bus.step_idx    = step_q;
  assign bus.step_start  = step_start_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.cfg_err     = cfg_err_q;

endmodule
